// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator datapath: widths, accumulator FSM states, clamp limits.
package accel_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/acc_add_sat.sv
// Combinational signed adder for the partial-sum accumulator.
// Optional macro ACC_SAT_EN: clamp on signed overflow and report it on o_ovf.
// Without the macro the sum wraps modulo 2^DATA_W and o_ovf is 0.
module acc_add_sat #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_ovf
);

  logic [DATA_W-1:0] w_wrap;

  // Wrapping sum; the carry out is discarded.
  assign w_wrap = i_a + i_b;

`ifdef ACC_SAT_EN
  logic w_ovf;

  // Overflow: operands share a sign that the wrapped result does not.
  assign w_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_wrap[DATA_W-1] != i_a[DATA_W-1]);

  // Clamp toward the operand sign on overflow.
  always_comb begin
    o_sum = w_wrap;
    if (w_ovf) begin
      o_sum = i_a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  assign o_ovf = w_ovf;
`else
  assign o_sum = w_wrap;
  assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates cfg_len consecutive adder-tree partial sums into one result and
// returns it through a valid/ready handshake.
// Optional macro ACC_SAT_EN: saturating adds with a sticky per-group out_sat flag.
module psum_accumulator
  import accel_pkg::*;
#(
  parameter int unsigned DATA_W = accel_pkg::DATA_W,
  parameter int unsigned LEN_W  = accel_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              busy
);

  state_t            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_sat;
  logic              r_busy;

  logic              w_accept;
  logic [LEN_W-1:0]  w_len_first;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_sum;
  logic              w_ovf;

  // Beat handshake, zero-length promotion and counter increment.
  assign w_accept    = in_valid && r_in_ready;
  assign w_len_first = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign w_cnt_nxt   = r_cnt + LEN_W'(1);

  acc_add_sat #(
    .DATA_W (DATA_W)
  ) u_add (
    .i_a   (r_acc),
    .i_b   (in_data),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // Group FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_len  <= w_len_first;
            r_acc  <= in_data;
            r_cnt  <= LEN_W'(1);
            r_sat  <= 1'b0;
            r_busy <= 1'b1;
            if (w_len_first == LEN_W'(1)) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_nxt;
            r_sat <= r_sat | w_ovf;
            if (w_cnt_nxt == r_len) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign out_sat   = r_sat;
  assign busy      = r_busy;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed, table-driven bench for psum_accumulator (honours ACC_SAT_EN when defined).
module tb_psum_accumulator;

  logic        clk;
  logic        rst_n;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        busy;

  int checks;
  int errors;

  psum_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       len;
    int               n;
    logic [3:0][31:0] beats;
    logic [31:0]      exp_data;
    logic             exp_sat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat for one cycle; in_ready must be high for it to be taken.
  task automatic beat(input string name, input logic [31:0] d);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Check a held result, then complete the output transfer.
  task automatic drain(input string name, input logic [31:0] exp_d, input logic exp_s);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_out_data"},  out_data, exp_d);
    chk({name, "_out_sat"},   32'(out_sat), 32'(exp_s));
    chk({name, "_busy"},      32'(busy), 32'd1);
    chk({name, "_hold_rdy"},  32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_idle_busy"},  32'(busy), 32'd0);
  endtask

  task automatic run_vec(input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    cfg_len = vecs[idx].len;
    for (int b = 0; b < vecs[idx].n; b++) begin
      chk({nm, "_early_valid"}, 32'(out_valid), 32'd0);
      beat(nm, vecs[idx].beats[b]);
    end
    drain(nm, vecs[idx].exp_data, vecs[idx].exp_sat);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    cfg_len   = 8'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    vecs[0] = '{len: 8'd2, n: 2, beats: {32'd0, 32'd0, 32'h88, 32'h88}, exp_data: 32'h110, exp_sat: 1'b0};
    vecs[1] = '{len: 8'd0, n: 1, beats: {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, exp_data: 32'hFFFF_FFFF, exp_sat: 1'b0};
    vecs[2] = '{len: 8'd1, n: 1, beats: {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFB}, exp_data: 32'hFFFF_FFFB, exp_sat: 1'b0};
    vecs[3] = '{len: 8'd4, n: 4, beats: {32'd4, 32'd3, 32'd2, 32'd1}, exp_data: 32'd10, exp_sat: 1'b0};
    vecs[4] = '{len: 8'd3, n: 3, beats: {32'd0, 32'hFFFF_FFE2, 32'd20, 32'hFFFF_FFF6}, exp_data: 32'hFFFF_FFEC, exp_sat: 1'b0};
`ifdef ACC_SAT_EN
    vecs[5] = '{len: 8'd2, n: 2, beats: {32'd0, 32'd0, 32'd1, 32'h7FFF_FFFF}, exp_data: 32'h7FFF_FFFF, exp_sat: 1'b1};
    vecs[7] = '{len: 8'd2, n: 2, beats: {32'd0, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000}, exp_data: 32'h8000_0000, exp_sat: 1'b1};
`else
    vecs[5] = '{len: 8'd2, n: 2, beats: {32'd0, 32'd0, 32'd1, 32'h7FFF_FFFF}, exp_data: 32'h8000_0000, exp_sat: 1'b0};
    vecs[7] = '{len: 8'd2, n: 2, beats: {32'd0, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000}, exp_data: 32'h7FFF_FFFF, exp_sat: 1'b0};
`endif
    vecs[6] = '{len: 8'd2, n: 2, beats: {32'd0, 32'd0, 32'd3, 32'd2}, exp_data: 32'd5, exp_sat: 1'b0};
    vecs[8] = '{len: 8'd2, n: 2, beats: {32'd0, 32'd0, 32'd3, 32'd2}, exp_data: 32'd5, exp_sat: 1'b0};

    // Reset values.
    #12;
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_sat",   32'(out_sat), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Table vectors.
    for (int i = 0; i < 9; i++) begin
      run_vec(i);
    end

    // Reset mid-group drops the partial result.
    cfg_len = 8'd4;
    beat("rstmid", 32'd5);
    beat("rstmid", 32'd6);
    chk("rstmid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_busy",      32'(busy), 32'd0);
    chk("rstmid_in_ready",  32'(in_ready), 32'd1);
    chk("rstmid_out_data",  out_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) beat("rstmid_fresh", 32'd1);
    drain("rstmid_fresh", 32'd4, 1'b0);

    // Bubbles between beats and backpressure on the output.
    cfg_len = 8'd3;
    beat("bp", 32'd10);
    for (int g = 0; g < 2; g++) begin
      tick();
      chk("bp_bubble_busy",  32'(busy), 32'd1);
      chk("bp_bubble_valid", 32'(out_valid), 32'd0);
    end
    beat("bp", 32'd20);
    beat("bp", 32'd30);
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int h = 0; h < 5; h++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data",  out_data, 32'd60);
      chk("bp_hold_rdy",   32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_xfer_valid", 32'(out_valid), 32'd0);
    chk("bp_xfer_rdy",   32'(in_ready), 32'd1);
    cfg_len = 8'd1;
    beat("bp_next", 32'd7);
    drain("bp_next", 32'd7, 1'b0);

    // cfg_len change after the first beat is ignored.
    cfg_len = 8'd4;
    beat("lenchg", 32'd1);
    cfg_len = 8'd1;
    beat("lenchg", 32'd1);
    beat("lenchg", 32'd1);
    chk("lenchg_early_valid", 32'(out_valid), 32'd0);
    beat("lenchg", 32'd1);
    drain("lenchg", 32'd4, 1'b0);

    // Maximum group length.
    cfg_len = 8'd255;
    for (int b = 0; b < 254; b++) beat("len255", 32'd1);
    chk("len255_early_valid", 32'(out_valid), 32'd0);
    beat("len255", 32'd1);
    drain("len255", 32'd255, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
